serial_to_parallel: RTL and testbench

- Receive-side counterpart of the MRAM burst serialiser.
- Deserialises an LSB-first bit stream into a BUS_WIDTH word, in full-word, lower-byte or upper-byte mode (same word_sel encoding as the transmit side).
- Presents the assembled word to the MRAM write path with a valid/ready handshake and flags overruns.

---
 rtl/serial_to_parallel.sv | 163 ++++++++++++++++
 tb/tb_serial_to_parallel.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel.sv
// LSB-first serial receiver for the MRAM write path: full/lower/upper word framing, valid/ready output, sticky overrun.
// Define S2P_PARITY_EN to append an even-parity bit to each frame and expose parity_err.
//
// state  | meaning
// IDLE   | waiting for start with a valid word_sel
// RECV   | shifting in the N data bits
// PARITY | waiting for the trailing parity bit (S2P_PARITY_EN only)
// DONE   | one cycle: load data_out, raise out_valid
module serial_to_parallel #(
  parameter int BUS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic [1:0]           word_sel,
  input  logic                 bit_valid,
  input  logic                 data_in,
  output logic [BUS_WIDTH-1:0] data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 overrun,
`ifdef S2P_PARITY_EN
  output logic                 parity_err,
`endif
  input  logic                 clr_overrun
);

  localparam int HALF  = BUS_WIDTH / 2;
  localparam int CNT_W = $clog2(BUS_WIDTH) + 1;

`ifdef S2P_PARITY_EN
  typedef enum logic [1:0] {IDLE, RECV, PARITY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
`endif

  state_t               state, state_nxt;
  logic [1:0]           sel_q;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     last_idx;
  logic [BUS_WIDTH-1:0] shift_q;
  logic [BUS_WIDTH-1:0] word_asm;
  logic                 frame_go;
  logic                 bit_take;
  logic                 load_out;
  logic                 ovr_event;
`ifdef S2P_PARITY_EN
  logic                 par_take;
  logic                 par_calc;
`endif

  assign last_idx = (sel_q == 2'b11) ? CNT_W'(BUS_WIDTH - 1) : CNT_W'(HALF - 1);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    frame_go  = 1'b0;
    bit_take  = 1'b0;
    load_out  = 1'b0;
`ifdef S2P_PARITY_EN
    par_take  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start && en && (word_sel != 2'b00)) begin
          frame_go  = 1'b1;
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (en && bit_valid) begin
          bit_take = 1'b1;
          if (cnt == last_idx) begin
`ifdef S2P_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = DONE;
`endif
          end
        end
      end
`ifdef S2P_PARITY_EN
      PARITY: begin
        if (en && bit_valid) begin
          par_take  = 1'b1;
          state_nxt = DONE;
        end
      end
`endif
      DONE: begin
        load_out  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Right shift: after N samples the frame occupies shift_q[BUS_WIDTH-1 -: N].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= 2'b00;
      cnt     <= '0;
      shift_q <= '0;
    end else if (frame_go) begin
      sel_q   <= word_sel;
      cnt     <= '0;
      shift_q <= '0;
    end else if (bit_take) begin
      shift_q <= {data_in, shift_q[BUS_WIDTH-1:1]};
      cnt     <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    word_asm = shift_q;
    if (sel_q == 2'b01)
      word_asm = {{HALF{1'b0}}, shift_q[BUS_WIDTH-1:HALF]};
    else if (sel_q == 2'b10)
      word_asm = {shift_q[BUS_WIDTH-1:HALF], {HALF{1'b0}}};
  end

`ifdef S2P_PARITY_EN
  // Half-word frames leave the lower half of shift_q at zero, so a full-width XOR is safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           par_calc <= 1'b0;
    else if (frame_go) par_calc <= 1'b0;
    else if (par_take) par_calc <= (^shift_q) ^ data_in;
  end
`endif

  assign ovr_event = load_out && out_valid && !out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
`ifdef S2P_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (load_out) begin
        data_out   <= word_asm;
        out_valid  <= 1'b1;
`ifdef S2P_PARITY_EN
        parity_err <= par_calc;
`endif
      end else if (out_valid && out_ready) begin
        out_valid  <= 1'b0;
      end
      if (ovr_event)        overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Randomised bench for serial_to_parallel: frames are built from bit lists and compared to a transaction-level model.
module tb_serial_to_parallel;

  localparam int W    = 16;
  localparam int HALF = W / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, start, bit_valid, data_in, out_ready, clr_overrun;
  logic [1:0]    word_sel;
  logic [W-1:0]  data_out;
  logic          out_valid, busy, overrun;
`ifdef S2P_PARITY_EN
  logic          parity_err;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  // transaction-level model of the output side
  logic [W-1:0] model_data;
  bit           model_valid;
  bit           model_ovr;

  // per-frame stimulus knobs
  bit gap_mode, rand_mode, start_mid, clr_at_done;
  int freeze_at, force_flip;

  serial_to_parallel #(.BUS_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .word_sel(word_sel),
    .bit_valid(bit_valid), .data_in(data_in), .data_out(data_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .overrun(overrun),
`ifdef S2P_PARITY_EN
    .parity_err(parity_err),
`endif
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected summary first");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [1:0] sel, input logic [W-1:0] value, input bit ready_at_done);
    int n, gaps;
    logic [W-1:0] exp_word;
    bit par, flip, ovr_exp;
    n = (sel == 2'b11) ? W : HALF;
    if (sel == 2'b11)      exp_word = value;
    else if (sel == 2'b01) exp_word = value & W'((1 << HALF) - 1);
    else                   exp_word = (value & W'((1 << HALF) - 1)) << HALF;
    par  = 1'b0;
    flip = 1'b0;
    @(negedge clk);
    start = 1'b1; word_sel = sel; en = 1'b1; bit_valid = 1'b0;
    if (model_valid) out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; word_sel = 2'b00;
    chk("busy_after_start", busy, 1);
    for (int k = 0; k < n; k++) begin
      gaps = gap_mode ? 1 : (rand_mode ? $urandom_range(0, 2) : 0);
      for (int g = 0; g < gaps; g++) begin
        if (rand_mode && $urandom_range(0, 1)) begin en = 1'b0; bit_valid = 1'b1; end
        else begin en = 1'b1; bit_valid = 1'b0; end
        data_in   = 1'($urandom);
        out_ready = model_valid ? 1'b0 : 1'($urandom);
        @(negedge clk);
      end
      en = 1'b1; bit_valid = 1'b1; data_in = value[k];
      out_ready = model_valid ? 1'b0 : 1'($urandom);
      par ^= value[k];
      if (start_mid && k == n / 2) begin start = 1'b1; word_sel = 2'b01; end
      @(negedge clk);
      start = 1'b0; word_sel = 2'b00; bit_valid = 1'b0;
      if (k == freeze_at) begin
        for (int f = 0; f < 5; f++) begin
          en = 1'b0; bit_valid = 1'b1; data_in = 1'($urandom);
          @(negedge clk);
          chk("busy_frozen", busy, 1);
        end
        en = 1'b1; bit_valid = 1'b0;
      end
    end
`ifdef S2P_PARITY_EN
    flip = (force_flip < 0) ? 1'($urandom) : 1'(force_flip);
    en = 1'b1; bit_valid = 1'b1; data_in = par ^ flip;
    @(negedge clk);
    bit_valid = 1'b0;
`endif
    // DONE cycle: nothing new visible yet
    out_ready   = ready_at_done;
    clr_overrun = clr_at_done;
    chk("busy_in_done", busy, 1);
    chk("valid_before_load", out_valid, 32'(model_valid));
    chk("data_before_load", data_out, 32'(model_data));
    ovr_exp = (model_ovr && !clr_at_done) || (model_valid && !ready_at_done);
    @(negedge clk);
    model_ovr = ovr_exp; model_valid = 1'b1; model_data = exp_word;
    out_ready = 1'b0; clr_overrun = 1'b0;
    chk("data_out", data_out, 32'(exp_word));
    chk("out_valid", out_valid, 1);
    chk("overrun", overrun, 32'(model_ovr));
    chk("busy_after_done", busy, 0);
`ifdef S2P_PARITY_EN
    chk("parity_err", parity_err, 32'(flip));
`endif
  endtask

  task automatic accept();
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    model_valid = 1'b0;
    chk("valid_after_accept", out_valid, 0);
  endtask

  task automatic clear_ovr();
    @(negedge clk); clr_overrun = 1'b1;
    @(negedge clk); clr_overrun = 1'b0;
    model_ovr = 1'b0;
    chk("overrun_cleared", overrun, 0);
  endtask

  task automatic clear_knobs();
    gap_mode = 0; rand_mode = 0; start_mid = 0; clr_at_done = 0;
    freeze_at = -1; force_flip = -1;
  endtask

  initial begin
    logic [1:0] sel;
    rst = 1'b1; en = 1'b1; start = 1'b0; word_sel = 2'b00; bit_valid = 1'b0;
    data_in = 1'b0; out_ready = 1'b0; clr_overrun = 1'b0;
    model_data = '0; model_valid = 0; model_ovr = 0;
    clear_knobs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data_out", data_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);

    send_frame(2'b11, 16'hA5C3, 0); accept();
    send_frame(2'b10, 16'h005A, 0); accept();
    send_frame(2'b01, 16'h003C, 0); accept();

    gap_mode = 1; freeze_at = 7;
    send_frame(2'b11, 16'h1234, 0); accept();
    clear_knobs();

    send_frame(2'b11, 16'h1111, 0);
    send_frame(2'b11, 16'h2222, 0);
    clear_ovr(); accept();
    send_frame(2'b11, 16'h1111, 0);
    send_frame(2'b11, 16'h2222, 1);
    clr_at_done = 1;
    send_frame(2'b11, 16'h3333, 0);
    clr_at_done = 0;
    clear_ovr(); accept();

    // abort a frame with reset while a word and an overrun are pending
    send_frame(2'b11, 16'h4444, 0);
    send_frame(2'b11, 16'h5555, 0);
    @(negedge clk); start = 1'b1; word_sel = 2'b11; en = 1'b1;
    @(negedge clk); start = 1'b0; word_sel = 2'b00;
    for (int k = 0; k < 5; k++) begin
      bit_valid = 1'b1; data_in = 1'b1;
      @(negedge clk);
    end
    bit_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_data_out", data_out, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_overrun", overrun, 0);
    @(negedge clk); rst = 1'b0;
    model_data = '0; model_valid = 0; model_ovr = 0;
    send_frame(2'b11, 16'h0F0F, 0); accept();

    @(negedge clk); start = 1'b1; word_sel = 2'b00;
    @(negedge clk); start = 1'b0;
    chk("start_sel00_ignored", busy, 0);
    en = 1'b0; start = 1'b1; word_sel = 2'b11;
    @(negedge clk); start = 1'b0; word_sel = 2'b00; en = 1'b1;
    chk("start_en_low_ignored", busy, 0);
    start_mid = 1;
    send_frame(2'b11, 16'hBEEF, 0); accept();
    send_frame(2'b10, 16'h00C5, 0); accept();
    clear_knobs();

`ifdef S2P_PARITY_EN
    force_flip = 1; send_frame(2'b11, 16'h0001, 0); accept();
    force_flip = 0; send_frame(2'b11, 16'h0001, 0); accept();
    clear_knobs();
`endif

    rand_mode = 1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       sel = 2'b01;
        1:       sel = 2'b10;
        default: sel = 2'b11;
      endcase
      start_mid   = ($urandom_range(0, 4) == 0);
      clr_at_done = ($urandom_range(0, 3) == 0);
      send_frame(sel, W'($urandom), 1'($urandom));
      if ($urandom_range(0, 1)) accept();
      if (model_ovr && $urandom_range(0, 1)) clear_ovr();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
